seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: digits per frame, legal 1..8.
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port seg_in  input  7  active-low segment pattern {g,f,e,d,c,b,a}; 0 = segment lit.
REQ-005 SHALL have port seg_valid  input  1  seg_in/seg_sof hold a beat.
REQ-006 SHALL have port seg_sof  input  1  beat is the first (most significant) digit of a frame.
REQ-007 SHALL have port seg_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port value  output  4*NUM_DIGITS  decoded frame; digit 0 of the frame in the top nibble.
REQ-009 SHALL have port err_mask  output  NUM_DIGITS  bit i set = digit in nibble i was not a legal pattern.
REQ-010 SHALL have port out_valid  output  1  value/err_mask hold a complete frame.
REQ-011 SHALL have port out_ready  input  1  consumer takes the frame.

Function
REQ-012 SHALL transfer a beat only when seg_valid and seg_ready are both 1 in the same cycle.
REQ-013 SHALL decode the legal patterns (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-014 SHALL decode any other pattern as nibble 0 and set that digit's err_mask bit.
REQ-015 SHALL implement states IDLE, COLLECT and HOLD.
REQ-016 IDLE: seg_ready=1; a beat with seg_sof=0 is accepted and discarded; a beat with seg_sof=1 is stored as digit 0, then COLLECT (or HOLD if NUM_DIGITS=1).
REQ-017 COLLECT: seg_ready=1; each beat shifts value left 4 bits and err_mask left 1 bit, inserting the new digit; the digit counter increments.
REQ-018 COLLECT: a beat with seg_sof=1 SHALL restart the frame; value and err_mask are cleared, and that beat becomes digit 0.
REQ-019 SHALL enter HOLD in the cycle after the NUM_DIGITS-th beat is accepted; out_valid=1 from that cycle on.
REQ-020 HOLD: seg_ready=0; value and err_mask stay stable; when out_ready=1, the block returns to IDLE next cycle and out_valid falls.
REQ-021 SHALL derive seg_ready combinationally from state only; it SHALL NOT depend on seg_valid.
REQ-022 value and err_mask SHALL change only in IDLE or COLLECT, and on reset.

Reset
REQ-023 Asserting resetn=0 SHALL immediately force state IDLE, digit counter 0, value 0, err_mask 0 and out_valid 0.
REQ-024 seg_ready SHALL be 0 while resetn=0 and 1 in the first cycle after release.
REQ-025 Reset asserted mid-frame or in HOLD SHALL drop the partial or held frame with no out_valid pulse.

Configuration
REQ-026 Macro SEG7_READER_BLANK_EN defined: pattern 7F (all segments off) SHALL decode as nibble 0 with no error.
REQ-027 Macro SEG7_READER_BLANK_EN undefined: pattern 7F SHALL be illegal per REQ-014.

Verification
REQ-028 Reset release, then beats 79(sof),24,30,19,12,02 back-to-back -> out_valid 1 cycle after 6th beat, value=0x123456, err_mask=0.
REQ-029 Beats 08(sof),03,46,21,06,0E with out_ready=0 for 5 cycles -> value=0xABCDEF held stable, seg_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-030 Frame with digit 3 = 55 -> value nibble 2 (digit 3) = 0, err_mask=6'b000100.
REQ-031 Beats 40(sof),79,24, then 18(sof),00,... 6 digits -> first partial frame discarded; value = 0x98xxxx from second frame only.
REQ-032 Beats 40(sof),79,24, then resetn=0 mid-frame -> out_valid stays 0; all outputs return to 0 immediately.
REQ-033 Pattern 7F in digit 0 -> err_mask bit 5 = 0 with SEG7_READER_BLANK_EN defined, 1 without.

Source files
------------

// File: rtl/seg7_reader.sv
// Collects active-low 7-segment digit patterns into a hex frame with per-digit error flags.
// Optional: define SEG7_READER_BLANK_EN to decode the all-off pattern 7F as a legal 0.
module seg7_reader #(
    parameter int unsigned NUM_DIGITS = 6
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [6:0]              seg_in,
    input  logic                    seg_valid,
    input  logic                    seg_sof,
    output logic                    seg_ready,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    localparam logic [3:0] LAST   = 4'(NUM_DIGITS);
    localparam logic       SINGLE = (NUM_DIGITS == 1);

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_err;
    logic                    r_out_valid;

    logic [3:0]              w_nib;
    logic                    w_bad;
    logic                    w_fire;
    logic [3:0]              w_cnt_nx;
    logic [4*NUM_DIGITS-1:0] w_nib_ext;
    logic [NUM_DIGITS-1:0]   w_err_ext;

    // Gating with resetn keeps ready low while reset is held, even though state is already IDLE.
    assign seg_ready = resetn & (r_state != HOLD);
    assign w_fire    = seg_valid & seg_ready;
    assign w_cnt_nx  = r_cnt + 4'd1;
    assign w_nib_ext = (4*NUM_DIGITS)'(w_nib);
    assign w_err_ext = NUM_DIGITS'(w_bad);

    assign value     = r_value;
    assign err_mask  = r_err;
    assign out_valid = r_out_valid;

    always_comb begin
        w_nib = 4'h0;
        w_bad = 1'b0;
        case (seg_in)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h18: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
`ifdef SEG7_READER_BLANK_EN
            7'h7F: w_nib = 4'h0;
`endif
            default: w_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_value     <= '0;
            r_err       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire && seg_sof) begin
                        r_value <= w_nib_ext;
                        r_err   <= w_err_ext;
                        r_cnt   <= 4'd1;
                        if (SINGLE) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (w_fire) begin
                        if (seg_sof) begin
                            r_value <= w_nib_ext;
                            r_err   <= w_err_ext;
                            r_cnt   <= 4'd1;
                        end else begin
                            r_value <= (r_value << 4) | w_nib_ext;
                            r_err   <= (r_err << 1) | w_err_ext;
                            r_cnt   <= w_cnt_nx;
                            if (w_cnt_nx == LAST) begin
                                r_state     <= HOLD;
                                r_out_valid <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader (NUM_DIGITS=6); expectations follow SEG7_READER_BLANK_EN.
module tb_seg7_reader;

    logic        clock;
    logic        resetn;
    logic [6:0]  seg_in;
    logic        seg_valid;
    logic        seg_sof;
    logic        seg_ready;
    logic [23:0] value;
    logic [5:0]  err_mask;
    logic        out_valid;
    logic        out_ready;

    int unsigned n_total;
    int unsigned n_fail;

    seg7_reader #(.NUM_DIGITS(6)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .seg_sof   (seg_sof),
        .seg_ready (seg_ready),
        .value     (value),
        .err_mask  (err_mask),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [6:0] pat, input logic sof);
        seg_in    = pat;
        seg_sof   = sof;
        seg_valid = 1'b1;
        @(posedge clock);
        #1;
        seg_valid = 1'b0;
        seg_sof   = 1'b0;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [5:0] blank_err;
        n_total   = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        seg_in    = 7'h7F;
        seg_valid = 1'b0;
        seg_sof   = 1'b0;
        out_ready = 1'b0;
`ifdef SEG7_READER_BLANK_EN
        blank_err = 6'b000000;
`else
        blank_err = 6'b100000;
`endif
        #3;
        check("rst_ready", 32'(seg_ready), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_value", 32'(value), 32'h0);
        check("rst_err", 32'(err_mask), 32'h0);
        step();
        step();
        resetn = 1'b1;
        step();
        check("post_rst_ready", 32'(seg_ready), 32'h1);

        // Frame 123456 back-to-back
        beat(7'h79, 1'b1);
        beat(7'h24, 1'b0);
        beat(7'h30, 1'b0);
        beat(7'h19, 1'b0);
        beat(7'h12, 1'b0);
        check("f1_not_yet_valid", 32'(out_valid), 32'h0);
        beat(7'h02, 1'b0);
        check("f1_valid", 32'(out_valid), 32'h1);
        check("f1_value", 32'(value), 32'h123456);
        check("f1_err", 32'(err_mask), 32'h0);
        check("f1_hold_ready", 32'(seg_ready), 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("f1_release_valid", 32'(out_valid), 32'h0);
        check("f1_release_ready", 32'(seg_ready), 32'h1);

        // Frame ABCDEF held 5 cycles while a stray beat is offered
        beat(7'h08, 1'b1);
        beat(7'h03, 1'b0);
        beat(7'h46, 1'b0);
        beat(7'h21, 1'b0);
        beat(7'h06, 1'b0);
        beat(7'h0E, 1'b0);
        seg_in    = 7'h40;
        seg_sof   = 1'b1;
        seg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("f2_hold_ready", 32'(seg_ready), 32'h0);
            check("f2_hold_value", 32'(value), 32'hABCDEF);
            check("f2_hold_valid", 32'(out_valid), 32'h1);
        end
        seg_valid = 1'b0;
        seg_sof   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("f2_release_valid", 32'(out_valid), 32'h0);
        check("f2_release_value", 32'(value), 32'hABCDEF);

        // Illegal pattern 55 in digit 3
        beat(7'h40, 1'b1);
        beat(7'h79, 1'b0);
        beat(7'h24, 1'b0);
        beat(7'h55, 1'b0);
        beat(7'h19, 1'b0);
        beat(7'h12, 1'b0);
        check("f3_value", 32'(value), 32'h012045);
        check("f3_err", 32'(err_mask), 32'h04);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Non-sof beats in IDLE are dropped without touching the last frame
        beat(7'h79, 1'b0);
        beat(7'h24, 1'b0);
        check("idle_drop_ready", 32'(seg_ready), 32'h1);
        check("idle_drop_valid", 32'(out_valid), 32'h0);
        check("idle_drop_value", 32'(value), 32'h012045);
        check("idle_drop_err", 32'(err_mask), 32'h04);

        // Restart mid-frame
        beat(7'h40, 1'b1);
        beat(7'h79, 1'b0);
        beat(7'h24, 1'b0);
        beat(7'h18, 1'b1);
        beat(7'h00, 1'b0);
        beat(7'h08, 1'b0);
        beat(7'h03, 1'b0);
        beat(7'h46, 1'b0);
        check("f4_pre_valid", 32'(out_valid), 32'h0);
        beat(7'h21, 1'b0);
        check("f4_valid", 32'(out_valid), 32'h1);
        check("f4_value", 32'(value), 32'h98ABCD);
        check("f4_err", 32'(err_mask), 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Blank pattern in digit 0
        beat(7'h7F, 1'b1);
        beat(7'h79, 1'b0);
        beat(7'h24, 1'b0);
        beat(7'h30, 1'b0);
        beat(7'h19, 1'b0);
        beat(7'h12, 1'b0);
        check("blank_value", 32'(value), 32'h012345);
        check("blank_err", 32'(err_mask), 32'(blank_err));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset mid-frame
        beat(7'h40, 1'b1);
        beat(7'h79, 1'b0);
        beat(7'h24, 1'b0);
        resetn = 1'b0;
        #2;
        check("midrst_value", 32'(value), 32'h0);
        check("midrst_err", 32'(err_mask), 32'h0);
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_ready", 32'(seg_ready), 32'h0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_valid", 32'(out_valid), 32'h0);
        end
        check("midrst_ready_after", 32'(seg_ready), 32'h1);

        // Reset while holding a frame
        beat(7'h78, 1'b1);
        beat(7'h78, 1'b0);
        beat(7'h78, 1'b0);
        beat(7'h78, 1'b0);
        beat(7'h78, 1'b0);
        beat(7'h78, 1'b0);
        check("f6_value", 32'(value), 32'h777777);
        check("f6_valid", 32'(out_valid), 32'h1);
        resetn = 1'b0;
        #2;
        check("holdrst_valid", 32'(out_valid), 32'h0);
        check("holdrst_value", 32'(value), 32'h0);
        step();
        resetn = 1'b1;
        step();
        check("holdrst_ready", 32'(seg_ready), 32'h1);
        check("holdrst_no_valid", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
